// File: rtl/fm_guard_loader.sv
// Round-robin loader: scatters the fm byte stream and the guard word stream across the
// per-column buffer write ports, then pulses load_done once a transfer is fully written.
module fm_guard_loader #(
    parameter int PE_COL   = 4,
    parameter int FM_DEPTH = 1024,
    parameter int GD_DEPTH = 256,
    parameter int FA_W     = $clog2(FM_DEPTH),
    parameter int GA_W     = $clog2(GD_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [FA_W+$clog2(PE_COL):0]  cfg_fm_len,
    input  logic [GA_W+$clog2(PE_COL):0]  cfg_gd_len,
    input  logic                          cfg_ping_pong,
    input  logic                          s_fm_valid,
    output logic                          s_fm_ready,
    input  logic [7:0]                    s_fm_data,
    input  logic                          s_gd_valid,
    output logic                          s_gd_ready,
    input  logic [5:0]                    s_gd_data,
    output logic [FA_W*PE_COL-1:0]        load_fm_wr_addr,
    output logic [8*PE_COL-1:0]           load_fm_din,
    output logic [PE_COL-1:0]             load_fm_wr_en,
    output logic [PE_COL-1:0]             load_fm_ping_pong,
    output logic [GA_W*PE_COL-1:0]        load_gd_wr_addr,
    output logic [6*PE_COL-1:0]           load_gd_din,
    output logic [PE_COL-1:0]             load_gd_wr_en,
    output logic [PE_COL-1:0]             load_gd_ping_pong,
    output logic                          load_done
);
    localparam int CW   = $clog2(PE_COL);
    localparam int FL_W = FA_W + CW + 1;
    localparam int GL_W = GA_W + CW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic            started;
    logic [FL_W-1:0] fm_len;
    logic [FL_W-1:0] fm_cnt;
    logic [GL_W-1:0] gd_len;
    logic [GL_W-1:0] gd_cnt;
    logic            ping_pong;
    logic            fm_fire;
    logic            gd_fire;
    logic            write_pending;
    logic [CW-1:0]   fm_col;
    logic [CW-1:0]   gd_col;
    logic [FA_W-1:0] fm_row;
    logic [GA_W-1:0] gd_row;

    // started keeps cfg_ready low while reset is held even though the FSM rests in IDLE
    assign cfg_ready  = started && (state == IDLE);
    assign s_fm_ready = (state == LOAD) && (fm_cnt < fm_len);
    assign s_gd_ready = (state == LOAD) && (gd_cnt < gd_len);
    assign fm_fire    = s_fm_valid && s_fm_ready;
    assign gd_fire    = s_gd_valid && s_gd_ready;
    assign load_done  = (state == DONE);

    assign load_fm_ping_pong = {PE_COL{ping_pong}};
    assign load_gd_ping_pong = {PE_COL{ping_pong}};

    // Over-long transfers simply wrap the row address inside the buffer depth
    assign fm_col = CW'(fm_cnt % FL_W'(PE_COL));
    assign fm_row = FA_W'(fm_cnt / FL_W'(PE_COL));
    assign gd_col = CW'(gd_cnt % GL_W'(PE_COL));
    assign gd_row = GA_W'(gd_cnt / GL_W'(PE_COL));

    assign write_pending = (|load_fm_wr_en) || (|load_gd_wr_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            started   <= 1'b0;
            fm_len    <= '0;
            gd_len    <= '0;
            fm_cnt    <= '0;
            gd_cnt    <= '0;
            ping_pong <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        fm_len    <= cfg_fm_len;
                        gd_len    <= cfg_gd_len;
                        ping_pong <= cfg_ping_pong;
                        fm_cnt    <= '0;
                        gd_cnt    <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (fm_fire) fm_cnt <= fm_cnt + FL_W'(1);
                    if (gd_fire) gd_cnt <= gd_cnt + GL_W'(1);
                    if ((fm_cnt == fm_len) && (gd_cnt == gd_len) && !write_pending) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // One registered write stage per stream; idle columns keep their last addr/din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_fm_wr_en   <= '0;
            load_fm_wr_addr <= '0;
            load_fm_din     <= '0;
            load_gd_wr_en   <= '0;
            load_gd_wr_addr <= '0;
            load_gd_din     <= '0;
        end else begin
            load_fm_wr_en <= '0;
            load_gd_wr_en <= '0;
            for (int j = 0; j < PE_COL; j++) begin
                if (fm_fire && (fm_col == CW'(j))) begin
                    load_fm_wr_en[j]                <= 1'b1;
                    load_fm_wr_addr[j*FA_W +: FA_W] <= fm_row;
                    load_fm_din[j*8 +: 8]           <= s_fm_data;
                end
                if (gd_fire && (gd_col == CW'(j))) begin
                    load_gd_wr_en[j]                <= 1'b1;
                    load_gd_wr_addr[j*GA_W +: GA_W] <= gd_row;
                    load_gd_din[j*6 +: 6]           <= s_gd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fm_guard_loader.sv
// Bench for fm_guard_loader: directed transfers plus randomized ones, every cycle compared
// against a beat-count model of where each accepted byte/word must land.
module tb_fm_guard_loader;
    localparam int PE_COL   = 4;
    localparam int FM_DEPTH = 1024;
    localparam int GD_DEPTH = 256;
    localparam int FA_W     = 10;
    localparam int GA_W     = 8;
    localparam int FL_W     = FA_W + 3;
    localparam int GL_W     = GA_W + 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [FL_W-1:0]        cfg_fm_len = '0;
    logic [GL_W-1:0]        cfg_gd_len = '0;
    logic                   cfg_ping_pong = 1'b0;
    logic                   s_fm_valid = 1'b0;
    logic                   s_fm_ready;
    logic [7:0]             s_fm_data = '0;
    logic                   s_gd_valid = 1'b0;
    logic                   s_gd_ready;
    logic [5:0]             s_gd_data = '0;
    logic [FA_W*PE_COL-1:0] load_fm_wr_addr;
    logic [8*PE_COL-1:0]    load_fm_din;
    logic [PE_COL-1:0]      load_fm_wr_en;
    logic [PE_COL-1:0]      load_fm_ping_pong;
    logic [GA_W*PE_COL-1:0] load_gd_wr_addr;
    logic [6*PE_COL-1:0]    load_gd_din;
    logic [PE_COL-1:0]      load_gd_wr_en;
    logic [PE_COL-1:0]      load_gd_ping_pong;
    logic                   load_done;

    always #5 clk = ~clk;

    fm_guard_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_fm_len        (cfg_fm_len),
        .cfg_gd_len        (cfg_gd_len),
        .cfg_ping_pong     (cfg_ping_pong),
        .s_fm_valid        (s_fm_valid),
        .s_fm_ready        (s_fm_ready),
        .s_fm_data         (s_fm_data),
        .s_gd_valid        (s_gd_valid),
        .s_gd_ready        (s_gd_ready),
        .s_gd_data         (s_gd_data),
        .load_fm_wr_addr   (load_fm_wr_addr),
        .load_fm_din       (load_fm_din),
        .load_fm_wr_en     (load_fm_wr_en),
        .load_fm_ping_pong (load_fm_ping_pong),
        .load_gd_wr_addr   (load_gd_wr_addr),
        .load_gd_din       (load_gd_din),
        .load_gd_wr_en     (load_gd_wr_en),
        .load_gd_ping_pong (load_gd_ping_pong),
        .load_done         (load_done)
    );

    int total = 0;
    int bad = 0;

    // Reference model: transfer descriptor, beats accepted so far, and buffer-port contents
    int   fm_len_m, gd_len_m, fm_acc, gd_acc;
    bit   pp_m, busy, last_done;
    int   done_seen, cyc, acc_cyc, done_cyc;
    int   exp_fm_addr [PE_COL];
    int   exp_fm_din  [PE_COL];
    int   exp_gd_addr [PE_COL];
    int   exp_gd_din  [PE_COL];
    logic [7:0] fm_data_q [$];
    logic [5:0] gd_data_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        fm_len_m = 0; gd_len_m = 0; fm_acc = 0; gd_acc = 0;
        pp_m = 1'b0; busy = 1'b0; last_done = 1'b0; done_seen = 0;
        for (int j = 0; j < PE_COL; j++) begin
            exp_fm_addr[j] = 0; exp_fm_din[j] = 0;
            exp_gd_addr[j] = 0; exp_gd_din[j] = 0;
        end
    endtask

    task automatic check_output(input logic [PE_COL-1:0] efe, input logic [PE_COL-1:0] ege);
        logic [FA_W*PE_COL-1:0] efa;
        logic [8*PE_COL-1:0]    efd;
        logic [GA_W*PE_COL-1:0] ega;
        logic [6*PE_COL-1:0]    egd;
        for (int j = 0; j < PE_COL; j++) begin
            efa[j*FA_W +: FA_W] = FA_W'(exp_fm_addr[j]);
            efd[j*8 +: 8]       = 8'(exp_fm_din[j]);
            ega[j*GA_W +: GA_W] = GA_W'(exp_gd_addr[j]);
            egd[j*6 +: 6]       = 6'(exp_gd_din[j]);
        end
        chk("fm_wr_en", 64'(load_fm_wr_en), 64'(efe));
        chk("fm_wr_addr", 64'(load_fm_wr_addr), 64'(efa));
        chk("fm_din", 64'(load_fm_din), 64'(efd));
        chk("gd_wr_en", 64'(load_gd_wr_en), 64'(ege));
        chk("gd_wr_addr", 64'(load_gd_wr_addr), 64'(ega));
        chk("gd_din", 64'(load_gd_din), 64'(egd));
        chk("fm_ping_pong", 64'(load_fm_ping_pong), 64'({PE_COL{pp_m}}));
        chk("gd_ping_pong", 64'(load_gd_ping_pong), 64'({PE_COL{pp_m}}));
        if (last_done) chk("cfg_ready_after_done", 64'(cfg_ready), 64'(1));
        if (load_done === 1'b1) begin
            chk("done_after_last_write",
                64'(busy && fm_acc == fm_len_m && gd_acc == gd_len_m && efe == 0 && ege == 0), 64'(1));
            done_seen++;
            done_cyc = cyc;
            busy = 1'b0;
        end
        last_done = (load_done === 1'b1);
    endtask

    // Advances one clock with the inputs currently driven and checks the cycle after the edge
    task automatic apply_stimulus();
        logic [PE_COL-1:0] efe;
        logic [PE_COL-1:0] ege;
        bit fm_hs, gd_hs, cfg_hs;
        int col;
        efe = '0;
        ege = '0;
        if (fm_acc >= fm_len_m) chk("fm_ready_low", 64'(s_fm_ready), 64'(0));
        if (gd_acc >= gd_len_m) chk("gd_ready_low", 64'(s_gd_ready), 64'(0));
        if (busy) chk("cfg_ready_busy", 64'(cfg_ready), 64'(0));
        fm_hs  = s_fm_valid && s_fm_ready;
        gd_hs  = s_gd_valid && s_gd_ready;
        cfg_hs = cfg_valid && cfg_ready;
        if (fm_hs) begin
            col = fm_acc % PE_COL;
            efe[col] = 1'b1;
            exp_fm_addr[col] = (fm_acc / PE_COL) % FM_DEPTH;
            exp_fm_din[col]  = int'(s_fm_data);
            fm_acc++;
        end
        if (gd_hs) begin
            col = gd_acc % PE_COL;
            ege[col] = 1'b1;
            exp_gd_addr[col] = (gd_acc / PE_COL) % GD_DEPTH;
            exp_gd_din[col]  = int'(s_gd_data);
            gd_acc++;
        end
        if (cfg_hs) begin
            fm_len_m = int'(cfg_fm_len);
            gd_len_m = int'(cfg_gd_len);
            pp_m = cfg_ping_pong;
            fm_acc = 0;
            gd_acc = 0;
            busy = 1'b1;
            done_seen = 0;
            acc_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_output(efe, ege);
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random
    task automatic run_transfer(input int fl, input int gl, input bit pp, input int fm_mode,
                                input int gd_mode, input bit hold_cfg, input bit inc_data);
        int budget;
        fm_data_q.delete();
        gd_data_q.delete();
        for (int i = 0; i < fl; i++) fm_data_q.push_back(inc_data ? 8'(16 + i) : 8'($urandom));
        for (int i = 0; i < gl; i++) gd_data_q.push_back(inc_data ? 6'(32 + i) : 6'($urandom));
        budget = 0;
        while (cfg_ready !== 1'b1 && budget < 20) begin
            apply_stimulus();
            budget++;
        end
        chk("cfg_ready_wait", 64'(cfg_ready), 64'(1));
        cfg_valid     = 1'b1;
        cfg_fm_len    = FL_W'(fl);
        cfg_gd_len    = GL_W'(gl);
        cfg_ping_pong = pp;
        s_fm_valid    = 1'b0;
        s_gd_valid    = 1'b0;
        apply_stimulus();
        if (!hold_cfg) cfg_valid = 1'b0;
        budget = 0;
        while (done_seen == 0 && budget < 4 * (fl + gl) + 20) begin
            case (fm_mode)
                0:       s_fm_valid = 1'b1;
                1:       s_fm_valid = (budget % 2 == 0);
                default: s_fm_valid = 1'($urandom_range(0, 1));
            endcase
            case (gd_mode)
                0:       s_gd_valid = 1'b1;
                1:       s_gd_valid = (budget % 2 == 0);
                default: s_gd_valid = 1'($urandom_range(0, 1));
            endcase
            s_fm_data = (fm_acc < fl) ? fm_data_q[fm_acc] : 8'hee;
            s_gd_data = (gd_acc < gl) ? gd_data_q[gd_acc] : 6'h2a;
            apply_stimulus();
            budget++;
        end
        cfg_valid  = 1'b0;
        s_fm_valid = 1'b0;
        s_gd_valid = 1'b0;
        apply_stimulus();
        apply_stimulus();
        chk("done_pulse_count", 64'(done_seen), 64'(1));
    endtask

    initial begin
        reset_model();
        cyc = 0;
        acc_cyc = 0;
        done_cyc = 0;
        #2;
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(0));
        chk("rst_load_done", 64'(load_done), 64'(0));
        chk("rst_fm_wr_en", 64'(load_fm_wr_en), 64'(0));
        chk("rst_gd_ready", 64'(s_gd_ready), 64'(0));
        @(negedge clk);
        apply_stimulus();
        rst_n = 1'b1;
        apply_stimulus();
        chk("cfg_ready_after_rst", 64'(cfg_ready), 64'(1));

        run_transfer(8, 4, 1'b1, 0, 0, 1'b0, 1'b1);
        chk("t1_fm_din_row1", 64'(load_fm_din), 64'(32'h17161514));
        chk("t1_fm_addr_row1", 64'(load_fm_wr_addr), 64'({4{10'd1}}));
        chk("t1_gd_addr_row0", 64'(load_gd_wr_addr), 64'(0));

        run_transfer(5, 0, 1'b0, 1, 0, 1'b0, 1'b1);
        chk("t2_col0_din", 64'(load_fm_din[7:0]), 64'(8'h14));
        chk("t2_col0_addr", 64'(load_fm_wr_addr[9:0]), 64'(1));

        run_transfer(0, 0, 1'b1, 0, 0, 1'b0, 1'b0);
        chk("t3_zero_done_latency", 64'(done_cyc - acc_cyc), 64'(2));

        run_transfer(6, 2, 1'b0, 0, 0, 1'b0, 1'b0);

        // Abort a transfer with reset after three fm beats
        cfg_valid = 1'b1; cfg_fm_len = FL_W'(8); cfg_gd_len = GL_W'(4); cfg_ping_pong = 1'b1;
        apply_stimulus();
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_fm_valid = 1'b1;
            s_fm_data  = 8'($urandom);
            apply_stimulus();
        end
        s_fm_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_fm_wr_en", 64'(load_fm_wr_en), 64'(0));
        chk("abort_cfg_ready", 64'(cfg_ready), 64'(0));
        chk("abort_load_done", 64'(load_done), 64'(0));
        reset_model();
        apply_stimulus();
        apply_stimulus();
        rst_n = 1'b1;
        apply_stimulus();
        apply_stimulus();
        chk("abort_no_done", 64'(done_seen), 64'(0));
        run_transfer(4, 4, 1'b0, 0, 0, 1'b0, 1'b1);

        run_transfer(7, 3, 1'b1, 0, 1, 1'b1, 1'b0);

        for (int t = 0; t < 5; t++) begin
            run_transfer($urandom_range(0, 40), $urandom_range(0, 20), 1'($urandom),
                         $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 1'b0);
        end

        run_transfer(0, PE_COL * GD_DEPTH + 4, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("gd_addr_wrap", 64'(load_gd_wr_addr), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
